elastic_pipe: RTL
=================

Name: elastic_pipe

Overview:
- Parametrised elastic buffer for valid/ready streams; successor to the single-skid pipe adapter.
- Provides DEPTH entries of buffering, with upstream ready decoded only from registered state. This breaks both the ready and data timing paths across long SLR/kernel routes.
- Adds occupancy and almost-full outputs for upstream throttling.
- Sits between the XRT stream interfaces and the core, and between core pipeline stages.

Parameters:
WIDTH, 512, payload width in bits
DEPTH, 4, number of storage entries; power of two, >= 2
AFULL_THRESH, DEPTH-1, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
us_valid  input  1  upstream data valid
us_data  input  WIDTH  upstream payload
us_ready  output  1  upstream ready; decoded from registered count only
ds_valid  output  1  downstream data valid
ds_data  output  WIDTH  downstream payload
ds_ready  input  1  downstream ready
count  output  $clog2(DEPTH+1)  current occupancy
almost_full  output  1  count >= AFULL_THRESH

Behaviour:
- Reset and clocking:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset clears wr_ptr, rd_ptr, count and all storage to 0.
  - While rst is high: us_ready=0, ds_valid=0, ds_data=0, count=0, almost_full=0.
  - Reset mid-transfer drops all buffered data; no partial beat survives.
- Handshakes:
  - Push when us_valid && us_ready. Pop when ds_valid && ds_ready.
  - us_ready = (count != DEPTH) && !rst. It has no combinational dependence on ds_ready or us_valid.
  - ds_valid = (count != 0).
  - ds_data = mem[rd_ptr] when ds_valid, else 0.
- Latency:
  - A beat pushed in cycle N appears on ds in cycle N+1 when the buffer was empty.
  - No combinational bypass.
  - Throughput is 1 beat/cycle sustained when ds_ready is held high.
- Pointers and count:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - count updates as: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Boundary conditions:
  - Full (count==DEPTH): us_ready=0. A pop in cycle N gives us_ready=1 in cycle N+1. A full buffer can therefore not accept in the same cycle as it drains; this is the intended registered-ready cost.
  - Empty (count==0): ds_valid=0. A simultaneous push is not visible until the next cycle.
  - Simultaneous push and pop at count 1..DEPTH-1: both occur and count is unchanged.
- Stability rules:
  - ds_valid and ds_data hold stable while ds_valid && !ds_ready.
  - Beats leave in strict order, with no loss and no duplication.
- us_valid may deassert without a handshake; the block makes no assumption on upstream stability.
- almost_full is a registered-state decode with the same timing as us_ready.

Optional Feature:
Macro ELASTIC_PIPE_PEAK_EN.
- With the macro defined:
  - Adds output port peak_count, width $clog2(DEPTH+1).
  - peak_count holds the maximum value count has reached since reset, updated the cycle after count changes.
  - Reset clears it to 0.
  - Adds input port peak_clr (1 bit). peak_clr=1 loads the current count, and takes priority over the max update in the same cycle.
- Without the macro: neither port exists, no peak logic is synthesised, and behaviour is otherwise identical.

Decomposition:
- Package elastic_pipe_pkg holds:
  - function cnt_w(depth) returning $clog2(depth+1);
  - ptr width helper;
  - elaboration-time check macros for DEPTH as a power of two and AFULL_THRESH range.
- One natural sub-module: elastic_pipe_mem.
  - DEPTH x WIDTH register array with a write port (we, waddr, wdata) and an asynchronous read (raddr, rdata), reset to 0.
  - Top-level elastic_pipe holds the pointers, count and handshake logic.

Test Plan:
- Reset then stream: WIDTH=32, DEPTH=4, ds_ready=1, push 0x1..0x10 back-to-back -> ds sees 0x1..0x10 in order starting one cycle after the first push, 1 beat/cycle; count stays at 1.
- Fill and stall: ds_ready=0, push 0xA0..0xA5 -> 0xA0..0xA3 accepted; us_ready=0 once count=4; almost_full=1 from count=3 (AFULL_THRESH=3).
- Drain from full: from the full state, ds_ready=1 for one cycle -> 0xA0 popped; us_ready=1 the next cycle, not the same cycle; 0xA4 is then accepted and ordering is kept.
- Random backpressure: 1000 beats, 50% random us_valid and ds_ready -> scoreboard matches exactly; ds_data is stable while stalled; count always equals pushes minus pops and stays <= 4.
- Reset mid-operation: count=3 with rst asserted for 1 cycle -> count=0, ds_valid=0, us_ready=0 during rst and 1 after; none of the old data is ever emitted.
- With ELASTIC_PIPE_PEAK_EN: fill to 4, drain to 1, pulse peak_clr -> peak_count=4 before the pulse, 1 after, then tracks the new maximum.

Source files
------------

// File: rtl/elastic_pipe_pkg.sv
// elastic_pipe_pkg
// Shared sizing helpers and elaboration-time parameter checks for the
// elastic_pipe buffer and its storage sub-module.
//   cnt_w(depth) : width of an occupancy counter able to hold 0..depth
//   ptr_w(depth) : width of a read/write pointer indexing 0..depth-1
//   EP_CHECK_DEPTH / EP_CHECK_AFULL : generate-level guards on parameters

`define EP_CHECK_DEPTH(d) \
    if (((d) < 2) || ((((d) - 1) & (d)) != 0)) begin : g_bad_depth \
        $error("elastic_pipe: DEPTH must be a power of two >= 2"); \
    end

`define EP_CHECK_AFULL(t, d) \
    if (((t) < 1) || ((t) > (d))) begin : g_bad_afull \
        $error("elastic_pipe: AFULL_THRESH must be in 1..DEPTH"); \
    end

package elastic_pipe_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/elastic_pipe_mem.sv
// elastic_pipe_mem
// DEPTH x WIDTH register file, one write port, one asynchronous read port.
// All entries clear on synchronous reset so no stale beat can leak out.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   we/waddr/wdata : write port
//   raddr/rdata    : combinational read port

module elastic_pipe_mem
    import elastic_pipe_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_pipe.sv
// elastic_pipe
// Elastic valid/ready buffer with DEPTH entries. us_ready and almost_full
// are decoded purely from the registered occupancy, so neither the ready
// path nor the data path crosses the block combinationally.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   us_valid/us_data/us_ready : upstream stream
//   ds_valid/ds_data/ds_ready : downstream stream (ds_data is 0 when idle)
//   count                  : current occupancy
//   almost_full            : count >= AFULL_THRESH
// Optional (macro ELASTIC_PIPE_PEAK_EN):
//   peak_clr               : load peak_count with the current count
//   peak_count             : highest count seen since reset / last clear

module elastic_pipe
    import elastic_pipe_pkg::*;
#(
    parameter int WIDTH        = 512,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      us_valid,
    input  logic [WIDTH-1:0]          us_data,
    output logic                      us_ready,
    output logic                      ds_valid,
    output logic [WIDTH-1:0]          ds_data,
    input  logic                      ds_ready,
    output logic [cnt_w(DEPTH)-1:0]   count,
`ifdef ELASTIC_PIPE_PEAK_EN
    input  logic                      peak_clr,
    output logic [cnt_w(DEPTH)-1:0]   peak_count,
`endif
    output logic                      almost_full
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

    `EP_CHECK_DEPTH(DEPTH)
    `EP_CHECK_AFULL(AFULL_THRESH, DEPTH)

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rdata;
    logic             push, pop;

    // Outputs are forced idle while rst is high even though the registers
    // only clear on the next edge.
    assign us_ready    = (cnt_q != FULL_C) && !rst;
    assign ds_valid    = (cnt_q != '0) && !rst;
    assign ds_data     = ds_valid ? rdata : '0;
    assign count       = rst ? '0 : cnt_q;
    assign almost_full = (cnt_q >= AFULL_C) && !rst;

    assign push = us_valid && us_ready;
    assign pop  = ds_valid && ds_ready;

    elastic_pipe_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (us_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef ELASTIC_PIPE_PEAK_EN
    // Tracks the registered count, so a new maximum shows one cycle later.
    logic [CW-1:0] peak_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else if (peak_clr) begin
            peak_q <= cnt_q;
        end else if (cnt_q > peak_q) begin
            peak_q <= cnt_q;
        end
    end

    assign peak_count = peak_q;
`endif

endmodule
